// File: rtl/sweep_pkg.sv
// Shared types and default widths for the triangle-sweep sequencer.
//   sweep_state_t : FSM state encoding used by sweep_ctrl
//   DefWidth      : default counter / limit width
//   DefDwellW     : default dwell counter width
//   DefSweepW     : default sweep-count width
package sweep_pkg;

  localparam int unsigned DefWidth  = 4;
  localparam int unsigned DefDwellW = 4;
  localparam int unsigned DefSweepW = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/updn_ld_cnt.sv
// Loadable up/down counter.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   en       : count enable
//   up_dwn_n : 1 = increment, 0 = decrement (when en)
//   ld       : synchronous load of d, takes priority over en
//   d        : load data
//   q        : current count
module updn_ld_cnt
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dwn_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      q_d = up_dwn_n ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer: drives an up/down counter between captured limits lo and hi,
// holding each endpoint for a programmable dwell, for a programmable number of sweeps
// (0 = run until stop).
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin a run (only looked at in IDLE)
//   stop       : synchronous abort, freezes cnt and returns to IDLE
//   lo, hi     : sweep limits, captured at start (lo < hi required)
//   dwell      : extra cycles held at each endpoint, captured at start
//   sweeps     : number of full sweeps, 0 = endless, captured at start
//   cnt        : current counter value
//   dir        : 1 while in UP or HOLD_HI
//   busy       : 1 in every state other than IDLE
//   done       : one-cycle pulse when the last sweep lands on lo
//   err        : one-cycle pulse after a rejected start (lo >= hi)
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned DWELL_W = DefDwellW,
  parameter int unsigned SWEEP_W = DefSweepW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [WIDTH-1:0]   cnt,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  sweep_state_t state_d, state_q;

  // Shadow copies of the run parameters, stable for the whole run.
  logic [WIDTH-1:0]   lo_d, lo_q;
  logic [WIDTH-1:0]   hi_d, hi_q;
  logic [DWELL_W-1:0] dwell_d, dwell_q;
  logic [SWEEP_W-1:0] sweeps_d, sweeps_q;

  logic [DWELL_W-1:0] dwell_cnt_d, dwell_cnt_q;
  logic [SWEEP_W-1:0] sweep_cnt_d, sweep_cnt_q;
  logic               done_d, done_q;
  logic               err_d, err_q;

  // Counter control.
  logic             cnt_en;
  logic             cnt_up;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_val;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [SWEEP_W-1:0] sweep_inc;

  assign cnt_inc   = cnt_val + WIDTH'(1);
  assign cnt_dec   = cnt_val - WIDTH'(1);
  assign sweep_inc = sweep_cnt_q + SWEEP_W'(1);

  updn_ld_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cnt_en),
    .up_dwn_n(cnt_up),
    .ld      (cnt_ld),
    .d       (lo),
    .q       (cnt_val)
  );

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    dwell_d     = dwell_q;
    sweeps_d    = sweeps_q;
    dwell_cnt_d = dwell_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_en      = 1'b0;
    cnt_up      = 1'b0;
    cnt_ld      = 1'b0;

    if (stop) begin
      // Abort from any running state; in IDLE a simultaneous start is dropped.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (lo < hi) begin
              lo_d        = lo;
              hi_d        = hi;
              dwell_d     = dwell;
              sweeps_d    = sweeps;
              sweep_cnt_d = '0;
              cnt_ld      = 1'b1;
              state_d     = UP;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        UP: begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
          if (cnt_inc == hi_q) begin
            if (dwell_q == '0) begin
              state_d = DOWN;
            end else begin
              dwell_cnt_d = dwell_q;
              state_d     = HOLD_HI;
            end
          end
        end

        HOLD_HI: begin
          // Leaving on a count of 1 makes hi visible for dwell+1 cycles, the
          // last of them in DOWN before the first decrement.
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          if (dwell_cnt_q == DWELL_W'(1)) begin
            state_d = DOWN;
          end
        end

        DOWN: begin
          cnt_en = 1'b1;
          cnt_up = 1'b0;
          if (cnt_dec == lo_q) begin
            sweep_cnt_d = sweep_inc;
            if ((sweeps_q != '0) && (sweep_inc == sweeps_q)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (dwell_q == '0) begin
              state_d = UP;
            end else begin
              dwell_cnt_d = dwell_q;
              state_d     = HOLD_LO;
            end
          end
        end

        HOLD_LO: begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          if (dwell_cnt_q == DWELL_W'(1)) begin
            state_d = UP;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      dwell_q     <= '0;
      sweeps_q    <= '0;
      dwell_cnt_q <= '0;
      sweep_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      dwell_q     <= dwell_d;
      sweeps_q    <= sweeps_d;
      dwell_cnt_q <= dwell_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cnt  = cnt_val;
  assign busy = (state_q != IDLE);
  assign dir  = (state_q == UP) || (state_q == HOLD_HI);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl. Each scenario pushes the expected per-cycle
// outputs into a scoreboard queue when it launches stimulus, then pops and compares
// one entry per clock, sampling on the falling edge.
module tb_sweep_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned SW = 8;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic [W-1:0]  lo     = '0;
  logic [W-1:0]  hi     = '0;
  logic [DW-1:0] dwell  = '0;
  logic [SW-1:0] sweeps = '0;
  logic [W-1:0]  cnt;
  logic          dir;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         dir;
    logic         done;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   busy_cycles  = 0;
  int   done_pulses  = 0;

  sweep_ctrl #(
    .WIDTH  (W),
    .DWELL_W(DW),
    .SWEEP_W(SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .lo    (lo),
    .hi    (hi),
    .dwell (dwell),
    .sweeps(sweeps),
    .cnt   (cnt),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void push(input int c, input bit b, input bit d, input bit dn, input bit e);
    exp_t x;
    x.cnt  = W'(c);
    x.busy = b;
    x.dir  = d;
    x.done = dn;
    x.err  = e;
    exp_q.push_back(x);
  endfunction

  // Reference trajectory built from the sweep description: up lo..hi-1, hi for dwell+1
  // cycles, down hi-1..lo+1, then either done on lo or a lo dwell before the next sweep.
  function automatic void push_model(input int l, input int h, input int dw, input int real_sw,
                                     input int n_sw);
    for (int s = 1; s <= n_sw; s++) begin
      for (int v = l; v < h; v++) push(v, 1, 1, 0, 0);
      for (int k = 0; k < dw; k++) push(h, 1, 1, 0, 0);
      push(h, 1, 0, 0, 0);
      for (int v = h - 1; v > l; v--) push(v, 1, 0, 0, 0);
      if (s == real_sw) push(l, 0, 0, 1, 0);
      else for (int k = 0; k < dw; k++) push(l, 1, 0, 0, 0);
    end
  endfunction

  task automatic start_run(input int l, input int h, input int dw, input int sw);
    @(negedge clk);
    lo     = W'(l);
    hi     = W'(h);
    dwell  = DW'(dw);
    sweeps = SW'(sw);
    start  = 1'b1;
  endtask

  task automatic drain(input string name, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s: scoreboard empty at cycle %0d", name, i);
        return;
      end
      e = exp_q.pop_front();
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_pulses++;
      tests_run++;
      if (cnt !== e.cnt) begin
        tests_failed++;
        $display("FAIL %s cnt[%0d]: got %0d expected %0d", name, i, cnt, e.cnt);
      end
      tests_run++;
      if (busy !== e.busy) begin
        tests_failed++;
        $display("FAIL %s busy[%0d]: got %b expected %b", name, i, busy, e.busy);
      end
      tests_run++;
      if (dir !== e.dir) begin
        tests_failed++;
        $display("FAIL %s dir[%0d]: got %b expected %b", name, i, dir, e.dir);
      end
      tests_run++;
      if (done !== e.done) begin
        tests_failed++;
        $display("FAIL %s done[%0d]: got %b expected %b", name, i, done, e.done);
      end
      tests_run++;
      if (err !== e.err) begin
        tests_failed++;
        $display("FAIL %s err[%0d]: got %b expected %b", name, i, err, e.err);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({cnt, dir, busy, done, err} !== {W'(0), 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset: got cnt=%0d dir=%b busy=%b done=%b err=%b expected all 0",
               cnt, dir, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_sweep();
    start_run(2, 5, 0, 1);
    push_model(2, 5, 0, 1, 1);
    push(2, 0, 0, 0, 0);
    busy_cycles = 0;
    done_pulses = 0;
    drain("single_sweep", exp_q.size());
    tests_run++;
    if (busy_cycles !== 6) begin
      tests_failed++;
      $display("FAIL single_sweep busy_cycles: got %0d expected 6", busy_cycles);
    end
    tests_run++;
    if (done_pulses !== 1) begin
      tests_failed++;
      $display("FAIL single_sweep done_pulses: got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_dwell();
    start_run(0, 3, 2, 2);
    push_model(0, 3, 2, 2, 2);
    push(0, 0, 0, 0, 0);
    busy_cycles = 0;
    done_pulses = 0;
    drain("dwell", exp_q.size());
    // Two 10-cycle periods, less the lo dwell that the final sweep never takes.
    tests_run++;
    if (busy_cycles !== 18) begin
      tests_failed++;
      $display("FAIL dwell busy_cycles: got %0d expected 18", busy_cycles);
    end
    tests_run++;
    if (done_pulses !== 1) begin
      tests_failed++;
      $display("FAIL dwell done_pulses: got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_reject();
    // Previous run ended on lo=0, so cnt must stay 0.
    start_run(5, 5, 0, 1);
    push(0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0);
    drain("reject_equal", 2);
    start_run(7, 2, 0, 1);
    push(0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0);
    drain("reject_inverted", 2);
  endtask

  task automatic test_stop();
    start_run(1, 4, 0, 0);
    push(1, 1, 1, 0, 0);
    push(2, 1, 1, 0, 0);
    push(3, 1, 1, 0, 0);
    drain("stop_run", 3);
    stop = 1'b1;
    for (int i = 0; i < 4; i++) push(3, 0, 0, 0, 0);
    drain("stop_frozen", 4);
  endtask

  task automatic test_busy_ignore_and_reset();
    start_run(2, 6, 1, 0);
    push_model(2, 6, 1, 0, 1);
    drain("busy_ignore_a", 3);
    lo     = 4'd0;
    hi     = 4'd9;
    dwell  = 4'd0;
    sweeps = 8'd1;
    start  = 1'b1;
    drain("busy_ignore_b", 5);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cnt !== W'(0)) begin
      tests_failed++;
      $display("FAIL async_reset cnt: got %0d expected 0", cnt);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset busy: got %b expected 0", busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    drain("after_reset", 2);
  endtask

  task automatic test_boundary();
    start_run(14, 15, 0, 3);
    push_model(14, 15, 0, 3, 3);
    push(14, 0, 0, 0, 0);
    done_pulses = 0;
    drain("boundary", exp_q.size());
    tests_run++;
    if (done_pulses !== 1) begin
      tests_failed++;
      $display("FAIL boundary done_pulses: got %0d expected 1", done_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_dwell();
    test_reject();
    test_stop();
    test_busy_ignore_and_reset();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
